// File: rtl/snapshot_ring_capture_if.sv
// snapshot_ring_capture_if
//   BRAM port A write bus driven by the snapshot capture engine.
//   master : capture engine (drives the write beat)
//   slave  : BRAM port A (or a monitor)
//   bram_we       write enable, one-cycle pulse per sample
//   bram_en_a     port enable, always equal to bram_we
//   bram_addr     write address, holds its value between beats
//   bram_wr_data  write data, holds its value between beats
interface snapshot_ring_capture_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              bram_we;
  logic              bram_en_a;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wr_data;

  modport master (
    output bram_we,
    output bram_en_a,
    output bram_addr,
    output bram_wr_data
  );

  modport slave (
    input bram_we,
    input bram_en_a,
    input bram_addr,
    input bram_wr_data
  );
endinterface

// File: rtl/snapshot_ring_capture.sv
// snapshot_ring_capture
//   Captures one channel of a multi-channel sample stream into BRAM port A.
//   mode 0 fills the buffer once from address 0; mode 1 runs a circular
//   pre-trigger capture, then writes post_len samples after the trigger
//   and reports where the trigger sample landed.
// Ports
//   clk, rst       clock, synchronous active-high reset
//   arm            rising edge starts (or restarts) a capture
//   mode           0 = immediate fill, 1 = triggered ring (latched on arm edge)
//   ch_sel         channel to capture (latched on arm edge)
//   post_len       samples after the trigger sample (latched on arm edge)
//   din, din_valid N_CH packed channels plus common sample strobe
//   trig           trigger, only honoured with din_valid in the PRE phase
//   bram           port A write bus (master side)
//   busy, done     capture in progress / capture complete
//   trig_addr      address holding the trigger sample
//   wrapped        ring wrapped at least once during the capture
module snapshot_ring_capture #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int N_CH     = 4,
  parameter int CH_SEL_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   mode,
  input  logic [CH_SEL_W-1:0]    ch_sel,
  input  logic [ADDR_W-1:0]      post_len,
  input  logic [N_CH*DATA_W-1:0] din,
  input  logic                   din_valid,
  input  logic                   trig,
  snapshot_ring_capture_if.master bram,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      trig_addr,
  output logic                   wrapped
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PRE,
    S_POST,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic                arm_d;
  logic                arm_edge;
  logic [CH_SEL_W-1:0] ch_reg, ch_next;
  logic [ADDR_W-1:0]   post_reg, post_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ADDR_W-1:0]   remaining_reg, remaining_next;
  logic [ADDR_W-1:0]   trig_addr_reg, trig_addr_next;
  logic                wrapped_reg, wrapped_next;
  logic                done_reg, done_next;
  logic                capturing;
  logic                accept;
  logic                addr_last;

  // write beat register stage (one cycle of latency to the BRAM)
  logic                we_reg;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic [DATA_W-1:0]   wr_data_reg;

  // channel split and selection
  logic [DATA_W-1:0]   ch_data [N_CH];
  logic [DATA_W-1:0]   sel_data;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign ch_data[gi] = din[gi*DATA_W +: DATA_W];
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_reg == CH_SEL_W'(k)) sel_data = ch_data[k];
    end
  end

  assign arm_edge  = arm & ~arm_d;
  assign capturing = (state_reg == S_FILL) || (state_reg == S_PRE) || (state_reg == S_POST);
  // A sample arriving together with an arm edge belongs to the aborted
  // capture and is dropped.
  assign accept    = capturing & din_valid & ~arm_edge;
  assign addr_last = (addr_reg == {ADDR_W{1'b1}});

  always_comb begin
    state_next     = state_reg;
    ch_next        = ch_reg;
    post_next      = post_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    trig_addr_next = trig_addr_reg;
    wrapped_next   = wrapped_reg;

    if (arm_edge) begin
      ch_next        = ch_sel;
      post_next      = post_len;
      addr_next      = '0;
      trig_addr_next = '0;
      wrapped_next   = 1'b0;
      state_next     = mode ? S_PRE : S_FILL;
    end else if (accept) begin
      addr_next = addr_reg + 1'b1;
      case (state_reg)
        S_FILL: begin
          if (addr_last) state_next = S_DONE;
        end
        S_PRE: begin
          if (addr_last) wrapped_next = 1'b1;
          if (trig) begin
            trig_addr_next = addr_reg;
            remaining_next = post_reg;
            state_next     = (post_reg == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (addr_last) wrapped_next = 1'b1;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == ADDR_W'(1)) state_next = S_DONE;
        end
        default: begin
        end
      endcase
    end

    // The state reaches DONE in the cycle of the final write beat; the
    // done flag follows one cycle later so it trails the last write.
    done_next = (state_reg == S_DONE) & ~arm_edge;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      // Track the arm level through reset so a level held high across
      // reset release is not seen as a fresh edge.
      arm_d         <= arm;
      ch_reg        <= '0;
      post_reg      <= '0;
      addr_reg      <= '0;
      remaining_reg <= '0;
      trig_addr_reg <= '0;
      wrapped_reg   <= 1'b0;
      done_reg      <= 1'b0;
      we_reg        <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      arm_d         <= arm;
      ch_reg        <= ch_next;
      post_reg      <= post_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      trig_addr_reg <= trig_addr_next;
      wrapped_reg   <= wrapped_next;
      done_reg      <= done_next;
      we_reg        <= accept;
      if (accept) begin
        wr_addr_reg <= addr_reg;
        wr_data_reg <= sel_data;
      end
    end
  end

  assign bram.bram_we      = we_reg;
  assign bram.bram_en_a    = we_reg;
  assign bram.bram_addr    = wr_addr_reg;
  assign bram.bram_wr_data = wr_data_reg;

  // busy also covers the final write beat, before done rises
  assign busy      = capturing | ((state_reg == S_DONE) & ~done_reg);
  assign done      = done_reg;
  assign trig_addr = trig_addr_reg;
  assign wrapped   = wrapped_reg;

endmodule

// File: tb/tb_snapshot_ring_capture.sv
// tb_snapshot_ring_capture
//   Directed bench for snapshot_ring_capture with a 16-entry buffer.
//   Each cyc() call presents one input cycle and returns 1 ns after the
//   next rising edge, where the write beat for that cycle's sample is
//   already visible on the BRAM bus.
module tb_snapshot_ring_capture;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int N_CH     = 4;
  localparam int CH_SEL_W = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   arm;
  logic                   mode;
  logic [CH_SEL_W-1:0]    ch_sel;
  logic [ADDR_W-1:0]      post_len;
  logic [N_CH*DATA_W-1:0] din;
  logic                   din_valid;
  logic                   trig;
  logic                   busy;
  logic                   done;
  logic [ADDR_W-1:0]      trig_addr;
  logic                   wrapped;

  int total = 0;
  int bad   = 0;

  snapshot_ring_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bram_if ();

  snapshot_ring_capture #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .N_CH    (N_CH),
    .CH_SEL_W(CH_SEL_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm),
    .mode     (mode),
    .ch_sel   (ch_sel),
    .post_len (post_len),
    .din      (din),
    .din_valid(din_valid),
    .trig     (trig),
    .bram     (bram_if.master),
    .busy     (busy),
    .done     (done),
    .trig_addr(trig_addr),
    .wrapped  (wrapped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Channel 2 carries d; the other channels carry distinct decoys.
  task automatic cyc(input logic v, input logic t, input logic [DATA_W-1:0] d);
    din_valid = v;
    trig      = t;
    din       = {32'hC3C30000 ^ d, d, 32'hA1A10000 ^ d, 32'hA0A00000 ^ d};
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    check({tag, "_we"},   bram_if.bram_we, 1);
    check({tag, "_en"},   bram_if.bram_en_a, 1);
    check({tag, "_addr"}, bram_if.bram_addr, a);
    check({tag, "_data"}, bram_if.bram_wr_data, d);
  endtask

  task automatic chk_idle_bus(input string tag);
    check({tag, "_we"}, bram_if.bram_we, 0);
    check({tag, "_en"}, bram_if.bram_en_a, 0);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; mode = 1'b0; ch_sel = '0; post_len = '0;
    din = '0; din_valid = 1'b0; trig = 1'b0;

    // ---------------- reset state
    repeat (3) cyc(0, 0, 0);
    rst = 1'b0;
    check("rst_we",    bram_if.bram_we, 0);
    check("rst_en",    bram_if.bram_en_a, 0);
    check("rst_addr",  bram_if.bram_addr, 0);
    check("rst_data",  bram_if.bram_wr_data, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_taddr", trig_addr, 0);
    check("rst_wrap",  wrapped, 0);
    cyc(0, 0, 0);
    check("idle_busy", busy, 0);

    // ---------------- immediate fill, channel 2
    arm = 1'b1; mode = 1'b0; ch_sel = 2'd2;
    cyc(0, 0, 0);
    ch_sel = 2'd1;  // must be ignored, channel was latched on the edge
    check("fill_busy0", busy, 1);
    chk_idle_bus("fill_arm");
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, DATA_W'(i));
      chk_wr($sformatf("fill%0d", i), ADDR_W'(i), DATA_W'(i));
      check($sformatf("fill%0d_busy", i), busy, 1);
    end
    check("fill_done_early", done, 0);
    cyc(0, 0, 0);
    check("fill_done",   done, 1);
    check("fill_busy",   busy, 0);
    check("fill_taddr",  trig_addr, 0);
    check("fill_wrap",   wrapped, 0);
    chk_idle_bus("fill_after");
    check("fill_hold_addr", bram_if.bram_addr, 15);
    check("fill_hold_data", bram_if.bram_wr_data, 15);
    cyc(1, 1, 32'h99);
    chk_idle_bus("fill_done_nowr");
    check("fill_done_held", done, 1);

    // ---------------- triggered, no wrap
    arm = 1'b0; cyc(0, 0, 0);
    arm = 1'b1; mode = 1'b1; post_len = 4'd3; ch_sel = 2'd2;
    cyc(0, 0, 0);
    check("trg_done_clr", done, 0);
    check("trg_busy",     busy, 1);
    for (int i = 0; i < 9; i++) begin
      cyc(1, i == 5, 32'h200 + DATA_W'(i));
      chk_wr($sformatf("trg%0d", i), ADDR_W'(i), 32'h200 + DATA_W'(i));
      if (i == 5) check("trg_taddr5", trig_addr, 5);
    end
    check("trg_done_early", done, 0);
    cyc(0, 0, 0);
    check("trg_done",  done, 1);
    check("trg_busy2", busy, 0);
    check("trg_taddr", trig_addr, 5);
    check("trg_wrap",  wrapped, 0);

    // ---------------- triggered with wrap, valid 1-in-3, trig during gaps ignored
    arm = 1'b0; cyc(0, 0, 0);
    arm = 1'b1; post_len = 4'd2;
    cyc(0, 0, 0);
    check("wrp_taddr_clr", trig_addr, 0);
    for (int n = 0; n < 23; n++) begin
      cyc(0, 1, 0);
      chk_idle_bus($sformatf("wrp%0d_gap", n));
      cyc(0, 1, 0);
      cyc(1, n == 20, 32'h300 + DATA_W'(n));
      chk_wr($sformatf("wrp%0d", n), ADDR_W'(n), 32'h300 + DATA_W'(n));
      if (n == 14) check("wrp_nowrap_yet", wrapped, 0);
      if (n == 15) check("wrp_wrap_set", wrapped, 1);
      if (n == 19) check("wrp_taddr_pre", trig_addr, 0);
      if (n == 20) check("wrp_taddr", trig_addr, 4);
    end
    check("wrp_done_early", done, 0);
    cyc(0, 0, 0);
    check("wrp_done",  done, 1);
    check("wrp_taddr2", trig_addr, 4);
    check("wrp_wrap",  wrapped, 1);

    // ---------------- trigger on first sample, post_len = 0
    arm = 1'b0; cyc(0, 0, 0);
    arm = 1'b1; post_len = 4'd0;
    cyc(0, 0, 0);
    check("one_wrap_clr", wrapped, 0);
    cyc(1, 1, 32'h77);
    chk_wr("one", 0, 32'h77);
    check("one_done_t1", done, 0);
    check("one_busy_t1", busy, 1);
    cyc(0, 0, 0);
    check("one_done_t2", done, 1);
    check("one_busy_t2", busy, 0);
    check("one_taddr",   trig_addr, 0);
    check("one_wrap",    wrapped, 0);
    chk_idle_bus("one_after");

    // ---------------- re-arm during POST, arm edge with trig
    arm = 1'b0; cyc(0, 0, 0);
    arm = 1'b1; post_len = 4'd5;
    cyc(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, i == 1, 32'h400 + DATA_W'(i));
      chk_wr($sformatf("rea%0d", i), ADDR_W'(i), 32'h400 + DATA_W'(i));
    end
    arm = 1'b0;
    cyc(1, 0, 32'h404);
    chk_wr("rea4", 4, 32'h404);
    check("rea_taddr1", trig_addr, 1);
    arm = 1'b1; post_len = 4'd1;
    cyc(1, 1, 32'h4FF);
    chk_idle_bus("rea_edge");
    check("rea_busy",  busy, 1);
    check("rea_done",  done, 0);
    check("rea_taddr", trig_addr, 0);
    cyc(1, 0, 32'h500);
    chk_wr("rea_a0", 0, 32'h500);
    cyc(1, 0, 32'h501);
    chk_wr("rea_a1", 1, 32'h501);
    cyc(1, 1, 32'h502);
    chk_wr("rea_a2", 2, 32'h502);
    check("rea_taddr2", trig_addr, 2);
    cyc(1, 0, 32'h503);
    chk_wr("rea_a3", 3, 32'h503);
    check("rea_done_early", done, 0);
    cyc(0, 0, 0);
    check("rea_done2", done, 1);

    // ---------------- reset during PRE with arm held high
    arm = 1'b0; cyc(0, 0, 0);
    arm = 1'b1; post_len = 4'd3;
    cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 32'h600 + DATA_W'(i));
      chk_wr($sformatf("mrst%0d", i), ADDR_W'(i), 32'h600 + DATA_W'(i));
    end
    rst = 1'b1;
    cyc(1, 1, 32'h6FF);
    check("mrst_we",    bram_if.bram_we, 0);
    check("mrst_en",    bram_if.bram_en_a, 0);
    check("mrst_addr",  bram_if.bram_addr, 0);
    check("mrst_data",  bram_if.bram_wr_data, 0);
    check("mrst_busy",  busy, 0);
    check("mrst_done",  done, 0);
    check("mrst_taddr", trig_addr, 0);
    check("mrst_wrap",  wrapped, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 32'h700 + DATA_W'(i));
      chk_idle_bus($sformatf("post_rst%0d", i));
      check($sformatf("post_rst%0d_busy", i), busy, 0);
      check($sformatf("post_rst%0d_done", i), done, 0);
    end
    arm = 1'b0; cyc(0, 0, 0);
    arm = 1'b1; mode = 1'b0;
    cyc(0, 0, 0);
    check("rearm_busy", busy, 1);
    cyc(1, 0, 32'h800);
    chk_wr("rearm", 0, 32'h800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
